// File: rtl/la_dsync_filter.sv
// Multi-channel async-input synchroniser with optional per-channel debounce
// filter and single-cycle rise/fall strobes on the qualified level.
module la_dsync_filter #(
   parameter                PROP   = "DEFAULT",
   parameter int            N      = 1,
   parameter int            STAGES = 2,
   parameter int            FILTER = 0,
   parameter logic [N-1:0]  RSTVAL = '0
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic [N-1:0] in,
   output logic [N-1:0] out,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall
);

   logic [STAGES-1:0][N-1:0] sync_q;
   logic [N-1:0]             sync;
   logic [N-1:0]             prev_q;

   // Sync chain: stage 0 samples the raw asynchronous inputs.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sync_q <= {STAGES{RSTVAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], in};
      end
   end

   assign sync = sync_q[STAGES-1];

   if (FILTER == 0) begin : g_bypass
      assign out = sync;
   end else begin : g_filter
      localparam int               CNT_W   = $clog2(FILTER + 1);
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER - 1);

      logic [N-1:0][CNT_W-1:0] cnt_q;
      logic [N-1:0][CNT_W-1:0] cnt_d;
      logic [N-1:0]            out_q;
      logic [N-1:0]            out_d;

      // Any cycle where sync agrees with out restarts the run, so glitches
      // shorter than FILTER cycles never propagate.
      always_comb begin
         cnt_d = cnt_q;
         out_d = out_q;
         for (int i = 0; i < N; i++) begin
            if (sync[i] == out_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
               out_d[i] = sync[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end

      always_ff @(posedge clk or negedge nreset) begin
         if (!nreset) begin
            cnt_q <= '0;
            out_q <= RSTVAL;
         end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
         end
      end

      assign out = out_q;
   end

   // prev tracks out one cycle behind; resetting it to RSTVAL keeps the
   // first post-release cycle free of strobes.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         prev_q <= RSTVAL;
      end else begin
         prev_q <= out;
      end
   end

   assign rise = out & ~prev_q;
   assign fall = ~out & prev_q;

endmodule

// File: tb/tb_la_dsync_filter.sv
// Scoreboard bench for la_dsync_filter: a filtered instance (STAGES=2,
// FILTER=3, RSTVAL=0101) and a bypass instance (STAGES=3, FILTER=0).
module tb_la_dsync_filter;

   typedef struct packed {
      logic [3:0] o;
      logic [3:0] r;
      logic [3:0] f;
   } exp_t;

   logic       clk = 1'b0;
   logic       nreset;
   logic [3:0] in_a, out_a, rise_a, fall_a;
   logic [3:0] in_b, out_b, rise_b, fall_b;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   la_dsync_filter #(
      .PROP("DEFAULT"), .N(4), .STAGES(2), .FILTER(3), .RSTVAL(4'b0101)
   ) dut_a (
      .clk(clk), .nreset(nreset), .in(in_a),
      .out(out_a), .rise(rise_a), .fall(fall_a)
   );

   la_dsync_filter #(
      .PROP("DEFAULT"), .N(4), .STAGES(3), .FILTER(0), .RSTVAL(4'b0000)
   ) dut_b (
      .clk(clk), .nreset(nreset), .in(in_b),
      .out(out_b), .rise(rise_b), .fall(fall_b)
   );

   task automatic settle(input logic [3:0] va, input logic [3:0] vb);
      in_a = va;
      in_b = vb;
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e, g;
      nreset = 1'b0;
      in_a   = 4'b1010;
      in_b   = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({out_a, rise_a, fall_a} !== {4'b0101, 4'b0000, 4'b0000}) begin
         failures++;
         $display("FAIL reset_hold_a got o=%b r=%b f=%b exp o=0101 r=0000 f=0000",
                  out_a, rise_a, fall_a);
      end
      checks++;
      if ({out_b, rise_b, fall_b} !== 12'h000) begin
         failures++;
         $display("FAIL reset_hold_b got o=%b r=%b f=%b exp all 0", out_b, rise_b, fall_b);
      end
      @(negedge clk);
      nreset = 1'b1;
      // in=1010 differs from RSTVAL on every bit: all bits flip after 2+3 edges
      for (int c = 0; c < 7; c++) begin
         e.o = (c >= 4) ? 4'b1010 : 4'b0101;
         e.r = (c == 4) ? 4'b1010 : 4'b0000;
         e.f = (c == 4) ? 4'b0101 : 4'b0000;
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({out_a, rise_a, fall_a} !== g) begin
            failures++;
            $display("FAIL reset_release c=%0d got o=%b r=%b f=%b exp o=%b r=%b f=%b",
                     c, out_a, rise_a, fall_a, g.o, g.r, g.f);
         end
      end
   endtask

   task automatic test_clean_change();
      exp_t e, g;
      settle(4'b0000, 4'b0000);
      for (int c = 0; c < 7; c++) begin
         in_a = 4'b0010;
         e.o = (c >= 4) ? 4'b0010 : 4'b0000;
         e.r = (c == 4) ? 4'b0010 : 4'b0000;
         e.f = 4'b0000;
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({out_a, rise_a, fall_a} !== g) begin
            failures++;
            $display("FAIL clean_change c=%0d got o=%b r=%b f=%b exp o=%b r=%b f=%b",
                     c, out_a, rise_a, fall_a, g.o, g.r, g.f);
         end
      end
   endtask

   task automatic test_glitch();
      exp_t e, g;
      settle(4'b0000, 4'b0000);
      for (int c = 0; c < 9; c++) begin
         in_a = (c < 2) ? 4'b0010 : 4'b0000;
         e = '0;
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({out_a, rise_a, fall_a} !== g) begin
            failures++;
            $display("FAIL glitch_2cyc c=%0d got o=%b r=%b f=%b exp o=%b r=%b f=%b",
                     c, out_a, rise_a, fall_a, g.o, g.r, g.f);
         end
      end
      // 3-cycle pulse survives: up after edge 5, down after edge 8
      for (int c = 0; c < 10; c++) begin
         in_a = (c < 3) ? 4'b0010 : 4'b0000;
         e.o = (c >= 4 && c <= 6) ? 4'b0010 : 4'b0000;
         e.r = (c == 4) ? 4'b0010 : 4'b0000;
         e.f = (c == 7) ? 4'b0010 : 4'b0000;
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({out_a, rise_a, fall_a} !== g) begin
            failures++;
            $display("FAIL pulse_3cyc c=%0d got o=%b r=%b f=%b exp o=%b r=%b f=%b",
                     c, out_a, rise_a, fall_a, g.o, g.r, g.f);
         end
      end
   endtask

   task automatic test_bypass();
      exp_t e, g;
      settle(4'b0000, 4'b0000);
      for (int c = 0; c < 9; c++) begin
         in_b = (c < 4) ? 4'b0001 : 4'b0000;
         e.o = (c >= 2 && c <= 5) ? 4'b0001 : 4'b0000;
         e.r = (c == 2) ? 4'b0001 : 4'b0000;
         e.f = (c == 6) ? 4'b0001 : 4'b0000;
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({out_b, rise_b, fall_b} !== g) begin
            failures++;
            $display("FAIL bypass c=%0d got o=%b r=%b f=%b exp o=%b r=%b f=%b",
                     c, out_b, rise_b, fall_b, g.o, g.r, g.f);
         end
      end
   endtask

   task automatic test_multi_channel();
      exp_t e, g;
      settle(4'b0000, 4'b0000);
      for (int c = 0; c < 10; c++) begin
         in_b = (c < 5) ? 4'b1111 : 4'b0000;
         e.o = (c >= 2 && c <= 6) ? 4'b1111 : 4'b0000;
         e.r = (c == 2) ? 4'b1111 : 4'b0000;
         e.f = (c == 7) ? 4'b1111 : 4'b0000;
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({out_b, rise_b, fall_b} !== g) begin
            failures++;
            $display("FAIL multi_channel c=%0d got o=%b r=%b f=%b exp o=%b r=%b f=%b",
                     c, out_b, rise_b, fall_b, g.o, g.r, g.f);
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t e, g;
      settle(4'b0000, 4'b0000);
      // Channels 1 and 2 count; after 4 edges cnt=2 and out is still 0000
      for (int c = 0; c < 4; c++) begin
         in_a = 4'b0110;
         e = '0;
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({out_a, rise_a, fall_a} !== g) begin
            failures++;
            $display("FAIL midcount_pre c=%0d got o=%b r=%b f=%b exp o=%b r=%b f=%b",
                     c, out_a, rise_a, fall_a, g.o, g.r, g.f);
         end
      end
      #2;
      nreset = 1'b0;
      #1;
      checks++;
      if ({out_a, rise_a, fall_a} !== {4'b0101, 4'b0000, 4'b0000}) begin
         failures++;
         $display("FAIL async_reset got o=%b r=%b f=%b exp o=0101 r=0000 f=0000",
                  out_a, rise_a, fall_a);
      end
      @(negedge clk);
      nreset = 1'b1;
      // Full 2+3 edges needed again: bit1 rises, bit0 falls, bit2 already 1
      for (int c = 0; c < 7; c++) begin
         in_a = 4'b0110;
         e.o = (c >= 4) ? 4'b0110 : 4'b0101;
         e.r = (c == 4) ? 4'b0010 : 4'b0000;
         e.f = (c == 4) ? 4'b0001 : 4'b0000;
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({out_a, rise_a, fall_a} !== g) begin
            failures++;
            $display("FAIL restart_count c=%0d got o=%b r=%b f=%b exp o=%b r=%b f=%b",
                     c, out_a, rise_a, fall_a, g.o, g.r, g.f);
         end
      end
   endtask

   initial begin
      nreset = 1'b0;
      in_a   = 4'b0000;
      in_b   = 4'b0000;
      test_reset();
      test_clean_change();
      test_glitch();
      test_bypass();
      test_multi_channel();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/la_dsync_filter.md
Name: la_dsync_filter

Overview:
Parametrised multi-channel synchroniser with asynchronous active-low reset, per-channel glitch filter and edge-pulse outputs. Each of N asynchronous inputs passes through a STAGES-deep flop chain. A per-channel debounce counter then qualifies the synchronised value, and single-cycle rise/fall strobes are generated. It sits at chip/IP boundaries for slow async controls such as straps, GPIO, interrupts and ready lines, which need a clean, debounced, edge-detected level in the clk domain.

Parameters:
PROP, "DEFAULT", implementation property string passed to the cell mapping; no functional effect.
N, 1, number of independent channels (>=1).
STAGES, 2, synchroniser depth in flops per channel (>=2).
FILTER, 0, debounce length in cycles. 0 = bypass. >=1 = the synchronised value must differ from `out` for FILTER consecutive cycles before `out` changes.
RSTVAL, 0, N-bit reset value of every sync stage and of `out`, per channel.

Ports:
clk  input  1  clock
nreset  input  1  asynchronous active-low reset
in  input  N  asynchronous input channels
out  output  N  synchronised, filtered level
rise  output  N  one-cycle pulse on each 0->1 transition of out[i]
fall  output  N  one-cycle pulse on each 1->0 transition of out[i]

Behaviour:
- Reset:
  - Clock is clk. Reset is nreset: asynchronous assert, active-low, synchronous release to clk.
  - While nreset=0, all sync stages of channel i = RSTVAL[i], out = RSTVAL, counters = 0, rise = 0, fall = 0.
  - No rise/fall pulse in the first cycle after release, whatever the value of in.
- Sync chain:
  - sync[i] = stage STAGES-1 of a shift chain clocked by clk.
  - A stable change on in[i] before edge k appears on sync[i] after edge k+STAGES-1.
- FILTER=0:
  - out = sync combinationally; no counters are instantiated.
  - Latency from in to out is STAGES edges.
- FILTER>=1:
  - Per-channel counter cnt[i], width $clog2(FILTER+1).
  - Each edge:
    - If sync[i]==out[i]: cnt[i] <= 0.
    - Else if cnt[i]==FILTER-1: out[i] <= sync[i], cnt[i] <= 0.
    - Else: cnt[i] <= cnt[i]+1.
  - Latency from in to out is STAGES+FILTER edges.
  - A glitch on sync shorter than FILTER cycles clears the counter and never reaches out.
  - The counter never exceeds FILTER-1; there is no wrap-around.
- Edge pulses:
  - prev[i] is a register, reset to RSTVAL[i], with prev <= out each edge.
  - rise = out & ~prev; fall = ~out & prev.
  - Each pulse lasts exactly one cycle, in the first cycle out shows the new value.
  - rise[i] and fall[i] are never high together.
  - With FILTER=0, rise/fall are combinational from the last sync stage.
- Channels are fully independent; simultaneous changes on several channels yield simultaneous pulses.
- Reset mid-operation: every in-flight value and partial count is discarded; out returns to RSTVAL immediately, asynchronously.
- Simulation: with `SIM` defined, the model may add a random 0/1-cycle extra delay per channel. The default build is deterministic.

Test Plan:
1. Reset values. N=4, STAGES=2, FILTER=3, RSTVAL=4'b0101. Hold nreset=0 with in=4'b1010 -> out=0101, rise=fall=0. Release -> no pulses in the first cycle.
2. Clean change. FILTER=3, in[1] 0->1 before edge 1 -> out[1]=1 after edge 5 (2+3). rise[1]=1 for exactly that one cycle, fall=0.
3. Glitch rejection. FILTER=3, in[1] high for 2 cycles then low -> out[1] stays 0, no pulses. A 3-cycle-wide pulse is passed and produces rise then fall.
4. Bypass. FILTER=0, STAGES=3, in[0] 0->1 before edge 1 -> out[0]=1 after edge 3. rise[0] is a single-cycle pulse, fall[0] asserts on the return to 0.
5. Multi-channel. in 0000->1111 simultaneously (RSTVAL=0) -> all out bits and all rise bits assert in the same cycle. Later in 1111->0000 -> all fall bits assert together.
6. Async reset mid-count. FILTER=3, assert nreset between edges while cnt[2]=2 -> out returns to RSTVAL immediately with no clock edge. After release, the count restarts from 0 (a full STAGES+FILTER edges are needed again).
